// File: rtl/eq_pkg.sv
// Shared constants and types for the LED VU meter.
package eq_pkg;

  localparam int LED_W = 8;
  localparam int AUD_W = 16;

  // Unsigned sample magnitude; the sign bit is stripped off.
  typedef logic [14:0] mag_t;

  // Larger of two magnitudes, used to merge the left and right channels.
  function automatic mag_t maxMag(input mag_t a, input mag_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vu_abs_sat.sv
// Saturating absolute value of a signed audio sample.
// The most negative sample (-32768) has no 15-bit magnitude, so it is
// clamped to 32767.
module vu_abs_sat
  import eq_pkg::*;
(
  input  logic [AUD_W-1:0] sample_i,
  output mag_t             mag_o
);

  logic [14:0] negLow;

  // For negative samples the low 15 bits of the two's complement give the
  // magnitude, except for -32768 where they wrap to zero.
  assign negLow = ~sample_i[14:0] + 15'd1;

  // Pick positive pass-through, saturated full scale or negated value.
  always_comb begin
    if (!sample_i[AUD_W-1]) begin
      mag_o = sample_i[14:0];
    end else if (sample_i[14:0] == 15'd0) begin
      mag_o = 15'h7FFF;
    end else begin
      mag_o = negLow;
    end
  end

endmodule

// File: rtl/led_vu_meter.sv
// Peak-hold LED bargraph with log-scale segments, timed peak decay and a
// clip indicator stretched over a few decay ticks.
module led_vu_meter
  import eq_pkg::*;
#(
  parameter int unsigned DECAY_PERIOD = 50000,
  parameter int unsigned HOLD_TICKS   = 200,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter logic [15:0] CLIP_LVL     = 16'h7F00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic [AUD_W-1:0] aud_lft,
  input  logic [AUD_W-1:0] aud_rght,
  output logic [LED_W-1:0] LED
);

  localparam int TICK_W = $clog2(DECAY_PERIOD);
  localparam int HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DECAY_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);

  mag_t magLft;
  mag_t magRght;

  mag_t mag_q;
  logic newSmp_q;

  logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
  logic              tick;

  mag_t              peak_q, peak_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [1:0]        clipCnt_q, clipCnt_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic load;
  logic clipHit;
  mag_t decShift;
  mag_t decStep;
  mag_t peakDecayed;
  logic [LED_W-1:0] bar;

  vu_abs_sat uAbsLft (
    .sample_i (aud_lft),
    .mag_o    (magLft)
  );

  vu_abs_sat uAbsRght (
    .sample_i (aud_rght),
    .mag_o    (magRght)
  );

  // Stage 1: capture the louder channel whenever a sample strobe arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q    <= '0;
      newSmp_q <= 1'b0;
    end else begin
      newSmp_q <= vld;
      if (vld) begin
        mag_q <= maxMag(magLft, magRght);
      end
    end
  end

  assign tick = (tickCnt_q == TICK_LAST);

  // Free-running decay timebase; wraps after DECAY_PERIOD cycles.
  always_comb begin
    tickCnt_d = tick ? '0 : tickCnt_q + TICK_W'(1);
  end

  assign load     = newSmp_q && (mag_q > peak_q);
  assign clipHit  = newSmp_q && ({1'b0, mag_q} >= CLIP_LVL);
  assign decShift = peak_q >> DECAY_SHIFT;
  assign decStep  = (decShift == '0) ? mag_t'(1) : decShift;
  assign peakDecayed = (peak_q > decStep) ? (peak_q - decStep) : '0;

  // Peak tracking: a louder sample always wins over a coincident tick, and a
  // tick only decays the peak once the hold period has run out.
  always_comb begin
    peak_d    = peak_q;
    holdCnt_d = holdCnt_q;
    if (load) begin
      peak_d    = mag_q;
      holdCnt_d = HOLD_INIT;
    end else if (tick) begin
      if (holdCnt_q != '0) begin
        holdCnt_d = holdCnt_q - HOLD_W'(1);
      end else begin
        peak_d = peakDecayed;
      end
    end
  end

  // Clip stretch counter runs off the decay ticks independently of the hold.
  always_comb begin
    clipCnt_d = clipCnt_q;
    if (clipHit) begin
      clipCnt_d = 2'd3;
    end else if (tick && (clipCnt_q != 2'd0)) begin
      clipCnt_d = clipCnt_q - 2'd1;
    end
  end

  // Log-scale segments: segment i lights once the peak reaches 0x80 << i.
  always_comb begin
    bar = '0;
    for (int i = 0; i < LED_W; i++) begin
      bar[i] = |(peak_q >> (7 + i));
    end
  end

  // Top segment doubles as the clip lamp.
  always_comb begin
    led_d = {bar[LED_W-1] | (clipCnt_q != 2'd0), bar[LED_W-2:0]};
  end

  // Stage 2 state, timebase and the registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      tickCnt_q <= '0;
      peak_q    <= '0;
      holdCnt_q <= '0;
      clipCnt_q <= '0;
      led_q     <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
      peak_q    <= peak_d;
      holdCnt_q <= holdCnt_d;
      clipCnt_q <= clipCnt_d;
      led_q     <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_led_vu_meter.sv
// Directed bench for led_vu_meter with a short decay period so the
// hold, decay and clip timing can be walked edge by edge.
module tb_led_vu_meter;

  localparam int unsigned DECAY_PERIOD = 4;
  localparam int unsigned HOLD_TICKS   = 2;
  localparam int unsigned DECAY_SHIFT  = 3;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [15:0] aud_lft;
  logic [15:0] aud_rght;
  logic [7:0]  LED;

  int checkCount = 0;
  int failCount  = 0;
  int edgeNo     = 0;

  typedef struct {
    logic [15:0] lft;
    logic [15:0] rght;
    logic [14:0] peak;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[12];

  led_vu_meter #(
    .DECAY_PERIOD (DECAY_PERIOD),
    .HOLD_TICKS   (HOLD_TICKS),
    .DECAY_SHIFT  (DECAY_SHIFT),
    .CLIP_LVL     (16'h7F00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .aud_lft  (aud_lft),
    .aud_rght (aud_rght),
    .LED      (LED)
  );

  // 100 MHz bench clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    edgeNo++;
  endtask

  task automatic runToEdge(input int k);
    while (edgeNo < k) stepCycle();
  endtask

  task automatic applyReset();
    rst      = 1'b1;
    vld      = 1'b0;
    aud_lft  = '0;
    aud_rght = '0;
    stepCycle();
    stepCycle();
    rst    = 1'b0;
    edgeNo = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
    vld      = 1'b1;
    aud_lft  = l;
    aud_rght = r;
    stepCycle();
    vld      = 1'b0;
    aud_lft  = '0;
    aud_rght = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    vld      = 1'b0;
    aud_lft  = '0;
    aud_rght = '0;

    vecs[0]  = '{16'h0100, 16'h0000, 15'h0100, 8'h03};
    vecs[1]  = '{16'h0000, 16'h0000, 15'h0000, 8'h00};
    vecs[2]  = '{16'h007F, 16'h0000, 15'h007F, 8'h00};
    vecs[3]  = '{16'h0080, 16'h0000, 15'h0080, 8'h01};
    vecs[4]  = '{16'hFF80, 16'h0000, 15'h0080, 8'h01};
    vecs[5]  = '{16'h0000, 16'h2000, 15'h2000, 8'h7F};
    vecs[6]  = '{16'h1000, 16'hC000, 15'h4000, 8'hFF};
    vecs[7]  = '{16'h8000, 16'h0000, 15'h7FFF, 8'hFF};
    vecs[8]  = '{16'h7EFF, 16'h0000, 15'h7EFF, 8'hFF};
    vecs[9]  = '{16'hFFFF, 16'h0001, 15'h0001, 8'h00};
    vecs[10] = '{16'h0400, 16'hFC00, 15'h0400, 8'h0F};
    vecs[11] = '{16'h8001, 16'h0000, 15'h7FFF, 8'hFF};

    // Single samples: nothing visible two edges after vld, result on the third
    for (int i = 0; i < 12; i++) begin
      applyReset();
      checkOutput($sformatf("v%0d_reset_led", i), 32'(LED), 32'h0);
      checkOutput($sformatf("v%0d_reset_peak", i), 32'(dut.peak_q), 32'h0);
      applyStimulus(vecs[i].lft, vecs[i].rght);
      stepCycle();
      checkOutput($sformatf("v%0d_led_early", i), 32'(LED), 32'h0);
      checkOutput($sformatf("v%0d_peak", i), 32'(dut.peak_q), 32'(vecs[i].peak));
      stepCycle();
      checkOutput($sformatf("v%0d_led", i), 32'(LED), 32'(vecs[i].led));
    end

    // Hold then decay: ticks land on edges 4, 8, 12, 16 after reset release
    applyReset();
    applyStimulus(16'h4000, 16'h0000);
    runToEdge(11);
    checkOutput("hold_peak_e11", 32'(dut.peak_q), 32'h4000);
    runToEdge(12);
    checkOutput("decay1_peak", 32'(dut.peak_q), 32'h3800);
    runToEdge(13);
    checkOutput("decay1_led", 32'(LED), 32'h7F);
    runToEdge(15);
    checkOutput("decay1_peak_e15", 32'(dut.peak_q), 32'h3800);
    runToEdge(16);
    checkOutput("decay2_peak", 32'(dut.peak_q), 32'h3100);

    // Peak of one decays to zero and stays there
    applyReset();
    applyStimulus(16'h0001, 16'h0000);
    runToEdge(3);
    checkOutput("one_led", 32'(LED), 32'h0);
    runToEdge(11);
    checkOutput("one_peak_e11", 32'(dut.peak_q), 32'h1);
    runToEdge(12);
    checkOutput("one_peak_zero", 32'(dut.peak_q), 32'h0);
    runToEdge(13);
    checkOutput("one_led_zero", 32'(LED), 32'h0);
    runToEdge(20);
    checkOutput("zero_peak_stays", 32'(dut.peak_q), 32'h0);
    checkOutput("zero_hold_stays", 32'(dut.holdCnt_q), 32'h0);
    checkOutput("zero_led_stays", 32'(LED), 32'h0);

    // Full-scale negative sample: clip stretch lasts three ticks
    applyReset();
    applyStimulus(16'h8000, 16'h0000);
    stepCycle();
    checkOutput("clip_cnt_set", 32'(dut.clipCnt_q), 32'h3);
    checkOutput("clip_peak", 32'(dut.peak_q), 32'h7FFF);
    stepCycle();
    checkOutput("clip_led", 32'(LED), 32'hFF);
    runToEdge(4);
    checkOutput("clip_cnt_tick1", 32'(dut.clipCnt_q), 32'h2);
    runToEdge(12);
    checkOutput("clip_cnt_expired", 32'(dut.clipCnt_q), 32'h0);
    checkOutput("clip_peak_decay", 32'(dut.peak_q), 32'h7000);
    runToEdge(13);
    checkOutput("clip_led_bar7_only", 32'(LED), 32'hFF);

    // Louder sample arriving on the tick edge beats the tick
    applyReset();
    applyStimulus(16'h0100, 16'h0000);
    runToEdge(2);
    applyStimulus(16'h0800, 16'h0000);
    stepCycle();
    checkOutput("tickload_peak", 32'(dut.peak_q), 32'h0800);
    checkOutput("tickload_hold", 32'(dut.holdCnt_q), 32'h2);
    runToEdge(8);
    checkOutput("tickload_hold_e8", 32'(dut.holdCnt_q), 32'h1);
    runToEdge(15);
    checkOutput("tickload_peak_e15", 32'(dut.peak_q), 32'h0800);
    runToEdge(16);
    checkOutput("tickload_decay", 32'(dut.peak_q), 32'h0700);

    // Back-to-back strobes, equal magnitude, then reset mid-flight
    applyReset();
    applyStimulus(16'h2000, 16'h0000);
    applyStimulus(16'h0200, 16'h0000);
    checkOutput("b2b_peak_e2", 32'(dut.peak_q), 32'h2000);
    stepCycle();
    checkOutput("b2b_peak_e3", 32'(dut.peak_q), 32'h2000);
    checkOutput("b2b_hold_e3", 32'(dut.holdCnt_q), 32'h2);
    stepCycle();
    checkOutput("b2b_led_e4", 32'(LED), 32'h7F);
    applyStimulus(16'h2000, 16'h0000);
    stepCycle();
    checkOutput("equal_no_reload", 32'(dut.holdCnt_q), 32'h1);
    checkOutput("equal_peak", 32'(dut.peak_q), 32'h2000);
    applyStimulus(16'h4000, 16'h0000);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst_led", 32'(LED), 32'h0);
    checkOutput("rst_peak", 32'(dut.peak_q), 32'h0);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rst_discard_peak", 32'(dut.peak_q), 32'h0);
    checkOutput("rst_discard_led", 32'(LED), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/led_vu_meter.md
LED_VU_METER -- requirements
Module: led_vu_meter

Interface
REQ-001 Parameter DECAY_PERIOD, default 50000, clk cycles per decay tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter HOLD_TICKS, default 200, decay ticks the peak is held after a new peak (200 ms).
REQ-003 Parameter DECAY_SHIFT, default 3, peak decrement per tick = max(peak>>DECAY_SHIFT, 1).
REQ-004 Parameter CLIP_LVL, default 16'h7F00, magnitude at or above which the clip indicator fires.
REQ-005 clk  input  1  50 MHz system clock; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 vld  input  1  one-cycle strobe from the I2S serf; audio inputs valid this cycle.
REQ-008 aud_lft  input  16  signed left sample (upper 16 bits of the 24-bit I2S word).
REQ-009 aud_rght  input  16  signed right sample.
REQ-010 LED  output  8  registered bargraph; LED[7] doubles as clip indicator.

Function
REQ-011 Stage 1, on vld: magnitude = |sample| per channel; -32768 saturates to 32767; register mag = max(|lft|, |rght|) as 15-bit unsigned, plus flag new_smp.
REQ-012 Stage 2, on new_smp: if mag > peak, then peak <= mag and hold_cnt <= HOLD_TICKS.
REQ-013 Tick counter free-runs 0..DECAY_PERIOD-1; tick asserts for one cycle at wrap.
REQ-014 On tick with no load this cycle: if hold_cnt != 0, then hold_cnt decrements; otherwise peak <= peak - max(peak>>DECAY_SHIFT, 1), floored at 0.
REQ-015 Same cycle load and tick: load wins; the tick is discarded for that cycle and the tick counter is not affected.
REQ-016 mag equal to peak: no load, no hold reload.
REQ-017 Bargraph: bar[i] = OR of peak[14:7+i] for i=0..7 (thresholds 0x0080, 0x0100, ... 0x4000, log2 scale); bar[0] lit iff peak >= 0x0080.
REQ-018 Clip: on new_smp with mag >= CLIP_LVL, clip_cnt <= 3 (decay ticks); clip_cnt decrements on each tick while nonzero, independent of hold.
REQ-019 LED <= {bar[7] | (clip_cnt != 0), bar[6:0]}, registered every cycle.
REQ-020 Latency: vld in cycle N -> peak updated in N+2 -> LED reflects it in N+3.
REQ-021 vld on consecutive cycles is accepted; every sample is processed with no drops.
REQ-022 peak never exceeds 0x7FFF; hold_cnt and clip_cnt never wrap below 0.

Reset
REQ-023 When rst is high at a clk edge: peak=0, hold_cnt=0, clip_cnt=0, tick counter=0, stage-1 registers=0, LED=8'h00.
REQ-024 rst mid-operation discards any in-flight sample; the first post-reset vld has REQ-020 latency.

Structure
REQ-025 Shared package eq_pkg holds the LED_W=8 constant, the AUD_W=16 constant, and the sample magnitude typedef (logic [14:0]).
REQ-026 One sub-module, vu_abs_sat, implements the saturating magnitude and is instantiated once per channel.
REQ-027 Registers only; no latches, no multipliers, no additional clocks or clock enables derived from data.

Verification
REQ-028 Reset, then vld with lft=16'h0100, rght=0 -> LED=8'b00000011 exactly 3 cycles after vld.
REQ-029 vld with lft=16'h8000 (-32768) -> peak=0x7FFF and LED=8'hFF; clip_cnt=3; after 3 ticks with no new samples LED[7] follows bar[7] only.
REQ-030 Load peak=0x4000 with DECAY_PERIOD=4 and HOLD_TICKS=2 -> peak unchanged through 2 ticks; 3rd tick gives 0x3800, 4th tick gives 0x3100.
REQ-031 Peak=1, hold expired -> next tick gives peak=0 and LED=0; further ticks keep it at 0 with no underflow.
REQ-032 Force vld with a larger mag on the same cycle as tick -> peak loads the new mag, hold reloads to HOLD_TICKS, and no decay is applied that cycle.
REQ-033 Back-to-back vld: 0x2000 then 0x0200 -> peak stays 0x2000; assert rst between samples -> LED=0 next cycle.
